cpu_bus_responder: RTL and testbench
====================================

Name: cpu_bus_responder

Overview:
- Responder for the CPU's single-port memory bus: separate read address and write address/data, with mem_rd and mem_wr strobes.
- Serves reads with a fixed 1-cycle latency, because the CPU has no stall input.
- Decodes the bus into three regions: on-chip RAM, a 16-word I/O window (console TX FIFO, status register, 32-bit cycle counter) and unmapped space.
- Sits between the cpu and the top level; the console byte stream leaves through a valid/ready port.

Parameters:
- AWIDTH, 16, bus address width.
- DWIDTH, 16, bus data width.
- RAM_AW, 12, log2 of RAM depth in words; RAM occupies addresses 0 .. 2^RAM_AW-1.
- IO_BASE, 16'hFFF0, base of the I/O window; window is addr[15:4]==IO_BASE[15:4].
- FIFO_AW, 4, log2 of console FIFO depth (16 entries).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- mem_raddr_i  in  AWIDTH  read address, sampled at posedge clk
- mem_rd_i  in  1  read strobe; when low, the rdata register holds its value
- mem_rdata_o  out  DWIDTH  read data, valid the cycle after the address is sampled
- mem_waddr_i  in  AWIDTH  write address
- mem_wdata_i  in  DWIDTH  write data
- mem_wr_i  in  1  write strobe, takes effect at posedge clk
- con_valid_o  out  1  console FIFO not empty
- con_data_o  out  8  console FIFO head byte
- con_ready_i  in  1  sink accepts; a pop occurs when con_valid_o & con_ready_i

Behaviour:
- Reset (async, rst_n=0):
  - mem_rdata_o=0, FIFO empty, con_valid_o=0, con_data_o=0.
  - overflow=0, cycle counter=0, hi_shadow=0.
  - RAM contents are not reset.
- Read latency: exactly 1 cycle. At posedge with mem_rd_i=1, the word at mem_raddr_i is registered into mem_rdata_o.
  - RAM is read-first: on a same-cycle write to the same address, the read returns the old word (unless WR_FWD_EN is defined).
- Writes: with mem_wr_i=1, the write commits at posedge and is visible to reads issued in later cycles.
- Region decode:
  - Write decode uses mem_waddr_i; read decode uses mem_raddr_i.
  - Unmapped reads return 0; unmapped writes are ignored.
  - The I/O window takes priority if it overlaps the RAM range.
- I/O offsets, relative to IO_BASE:
  - 0x0 CON_DATA: write pushes wdata[7:0] into the FIFO. If the FIFO is full and no pop occurs in the same cycle, the byte is dropped and overflow is set (sticky). Reads return 0.
  - 0x1 CON_STATUS: read returns {13'b0, overflow, full, empty}. Writing 1 to bit 2 clears overflow. If a clear and a new overflow happen in the same cycle, the new overflow wins.
  - 0x2 CYCLE_LO: read returns counter[15:0] and, in the same cycle, copies counter[31:16] into hi_shadow. The latch fires only when mem_rd_i=1. An instruction prefetch that hits this address also latches; this is accepted.
  - 0x3 CYCLE_HI: read returns hi_shadow.
  - 0x4–0xF: reserved; read 0, writes ignored.
- Cycle counter: 32 bits, increments every cycle after reset, wraps 0xFFFFFFFF→0. Not writable.
- Console FIFO:
  - Push and pop in the same cycle are both honoured.
  - When full, a push is accepted if a pop occurs in the same cycle.
  - con_data_o is the registered head entry; con_valid_o equals !empty.
  - Occupancy is held in a FIFO_AW+1 bit count.
- Read mux: the region select is registered alongside the RAM read, so RAM data and I/O data align on the same output cycle.

Optional Feature:
- Macro WR_FWD_EN.
- Defined: if mem_wr_i=1, mem_rd_i=1, mem_waddr_i==mem_raddr_i and the address decodes to RAM, mem_rdata_o returns mem_wdata_i (write-first).
- Undefined: read-first, returns the old RAM word.
- I/O registers are unaffected either way. The write to CON_STATUS and a read of it in the same cycle return the pre-write value in both builds.

Decomposition:
- Package cpu_bus_pkg:
  - I/O offset constants: CON_DATA=4'h0, CON_STATUS=4'h1, CYCLE_LO=4'h2, CYCLE_HI=4'h3.
  - Status bit indices.
  - Region-select encoding: RGN_RAM, RGN_IO, RGN_NONE.
- Sub-module sync_fifo (params DW, AW): push/pop/full/empty/count, registered head. It is reused later for a UART RX path.

Test Plan:
- Write 0x0010=0xBEEF, then read 0x0010 in the next cycle → mem_rdata_o=0xBEEF exactly one cycle after raddr is presented.
- RAM 0x0020 preloaded with 0x1111, then write 0x2222 and read 0x0020 in the same cycle → rdata 0x1111 without WR_FWD_EN, 0x2222 with it; next read → 0x2222 in both builds.
- With con_ready_i=0, write 16 bytes 0x41..0x50 to IO_BASE+0 → status=0x0002. A 17th write 0x51 → status=0x0006 and the FIFO is unchanged. Write 0x0004 to status → status=0x0002.
- Raise con_ready_i=1 → 0x41..0x50 come out one per cycle, in order, with no gaps; con_valid_o drops after the 16th; status=0x0001. Reads of unmapped 0x8000 → 0.
- Force counter=0x0000FFFF: read CYCLE_LO → 0xFFFF; read CYCLE_HI 3 cycles later → 0x0000 (shadow), although the live high half is 0x0001.
- Assert rst_n=0 mid-drain, between clock edges → con_valid_o=0 and mem_rdata_o=0 immediately. After release: status=0x0001 and the counter restarts from 0.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// Shared constants for the CPU bus responder: I/O register offsets,
// status bit positions and the region-select encoding.
package cpu_bus_pkg;

    localparam logic [3:0] CON_DATA   = 4'h0;
    localparam logic [3:0] CON_STATUS = 4'h1;
    localparam logic [3:0] CYCLE_LO   = 4'h2;
    localparam logic [3:0] CYCLE_HI   = 4'h3;

    localparam int STAT_EMPTY = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_OVF   = 2;

    typedef enum logic [1:0] {
        RGN_NONE = 2'd0,
        RGN_RAM  = 2'd1,
        RGN_IO   = 2'd2
    } rgn_t;

endpackage

// File: rtl/cpu_bus_responder_sync_fifo.sv
// Synchronous FIFO with a registered head entry; pushes into a full FIFO are
// accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam logic [AW:0] DEPTH = (AW+1)'(1) << AW;

    logic [DW-1:0] mem [2**AW];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_ptr_n;
    logic [AW:0]   count_q;
    logic [AW:0]   remain;
    logic [DW-1:0] head_q;
    logic [DW-1:0] head_n;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == DEPTH);
    assign count   = count_q;
    assign head    = head_q;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign rd_ptr_n = rd_ptr + AW'(do_pop);
    assign remain   = count_q - (AW+1)'(do_pop);

    // Head is pre-fetched so the consumer sees a flop output, not a RAM read.
    always_comb begin
        head_n = head_q;
        if (remain == '0) begin
            if (do_push) head_n = push_data;
        end else begin
            head_n = mem[rd_ptr_n];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            head_q  <= '0;
        end else begin
            wr_ptr  <= wr_ptr + AW'(do_push);
            rd_ptr  <= rd_ptr_n;
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
            head_q  <= head_n;
        end
    end

endmodule

// File: rtl/cpu_bus_responder.sv
// Memory-bus responder: on-chip RAM, a 16-word I/O window and unmapped space,
// 1-cycle read latency. Define WR_FWD_EN for write-first RAM forwarding.
module cpu_bus_responder
    import cpu_bus_pkg::*;
#(
    parameter int                AWIDTH  = 16,
    parameter int                DWIDTH  = 16,
    parameter int                RAM_AW  = 12,
    parameter logic [AWIDTH-1:0] IO_BASE = 16'hFFF0,
    parameter int                FIFO_AW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AWIDTH-1:0] mem_raddr_i,
    input  logic              mem_rd_i,
    output logic [DWIDTH-1:0] mem_rdata_o,
    input  logic [AWIDTH-1:0] mem_waddr_i,
    input  logic [DWIDTH-1:0] mem_wdata_i,
    input  logic              mem_wr_i,
    output logic              con_valid_o,
    output logic [7:0]        con_data_o,
    input  logic              con_ready_i
);

    // I/O window wins over RAM if the two ever overlap.
    function automatic rgn_t decode(input logic [AWIDTH-1:0] a);
        if (a[AWIDTH-1:4] == IO_BASE[AWIDTH-1:4]) return RGN_IO;
        else if ((a >> RAM_AW) == '0)            return RGN_RAM;
        else                                      return RGN_NONE;
    endfunction

    logic [DWIDTH-1:0] ram [2**RAM_AW];
    logic [DWIDTH-1:0] ram_q;
    logic [DWIDTH-1:0] io_q;
    logic [DWIDTH-1:0] io_rd_val;
    rgn_t              rgn_q;
    rgn_t              r_rgn;
    rgn_t              w_rgn;
    logic [3:0]        r_off;
    logic [3:0]        w_off;
    logic [RAM_AW-1:0] r_idx;
    logic [RAM_AW-1:0] w_idx;
    logic [31:0]       cnt;
    logic [15:0]       hi_shadow;
    logic              ovf;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FIFO_AW:0]  fifo_count;
    logic              fifo_push;
    logic              fifo_pop;
    logic              con_wr;
    logic              ovf_set;
    logic              ovf_clr;

    assign r_rgn = decode(mem_raddr_i);
    assign w_rgn = decode(mem_waddr_i);
    assign r_off = mem_raddr_i[3:0];
    assign w_off = mem_waddr_i[3:0];
    assign r_idx = mem_raddr_i[RAM_AW-1:0];
    assign w_idx = mem_waddr_i[RAM_AW-1:0];

    always_ff @(posedge clk) begin
        if (mem_wr_i && w_rgn == RGN_RAM) ram[w_idx] <= mem_wdata_i;
    end

`ifdef WR_FWD_EN
    logic fwd_hit;
    assign fwd_hit = mem_wr_i && (w_rgn == RGN_RAM) && (mem_waddr_i == mem_raddr_i);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_q <= '0;
        end else if (mem_rd_i && r_rgn == RGN_RAM) begin
`ifdef WR_FWD_EN
            ram_q <= fwd_hit ? mem_wdata_i : ram[r_idx];
`else
            ram_q <= ram[r_idx];
`endif
        end
    end

    always_comb begin
        io_rd_val = '0;
        case (r_off)
            CON_STATUS: io_rd_val = DWIDTH'({ovf, fifo_full, fifo_empty});
            CYCLE_LO:   io_rd_val = DWIDTH'(cnt[15:0]);
            CYCLE_HI:   io_rd_val = DWIDTH'(hi_shadow);
            default:    io_rd_val = '0;
        endcase
    end

    // Region select travels with the data so RAM and I/O results line up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgn_q     <= RGN_NONE;
            io_q      <= '0;
            hi_shadow <= '0;
        end else if (mem_rd_i) begin
            rgn_q <= r_rgn;
            if (r_rgn == RGN_IO) begin
                io_q <= io_rd_val;
                if (r_off == CYCLE_LO) hi_shadow <= cnt[31:16];
            end
        end
    end

    always_comb begin
        mem_rdata_o = '0;
        case (rgn_q)
            RGN_RAM: mem_rdata_o = ram_q;
            RGN_IO:  mem_rdata_o = io_q;
            default: mem_rdata_o = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else        cnt <= cnt + 32'd1;
    end

    assign con_wr    = mem_wr_i && (w_rgn == RGN_IO) && (w_off == CON_DATA);
    assign fifo_pop  = con_valid_o && con_ready_i;
    assign fifo_push = con_wr && (!fifo_full || fifo_pop);
    assign ovf_set   = con_wr && fifo_full && !fifo_pop;
    assign ovf_clr   = mem_wr_i && (w_rgn == RGN_IO) && (w_off == CON_STATUS)
                       && mem_wdata_i[STAT_OVF];

    // A fresh overflow beats a clear landing in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       ovf <= 1'b0;
        else if (ovf_set) ovf <= 1'b1;
        else if (ovf_clr) ovf <= 1'b0;
    end

    sync_fifo #(
        .DW (8),
        .AW (FIFO_AW)
    ) u_con_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (mem_wdata_i[7:0]),
        .pop       (fifo_pop),
        .head      (con_data_o),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign con_valid_o = (fifo_count != '0);

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Directed bench for cpu_bus_responder with scoreboard queues for read data
// and the console byte stream.
module tb_cpu_bus_responder;
    import cpu_bus_pkg::*;

    localparam logic [15:0] IO_BASE = 16'hFFF0;
`ifdef WR_FWD_EN
    localparam logic [15:0] SAME_CYC_EXP = 16'h2222;
`else
    localparam logic [15:0] SAME_CYC_EXP = 16'h1111;
`endif

    logic        clk;
    logic        rst_n;
    logic [15:0] mem_raddr_i;
    logic        mem_rd_i;
    logic [15:0] mem_rdata_o;
    logic [15:0] mem_waddr_i;
    logic [15:0] mem_wdata_i;
    logic        mem_wr_i;
    logic        con_valid_o;
    logic [7:0]  con_data_o;
    logic        con_ready_i;

    cpu_bus_responder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_raddr_i (mem_raddr_i),
        .mem_rd_i    (mem_rd_i),
        .mem_rdata_o (mem_rdata_o),
        .mem_waddr_i (mem_waddr_i),
        .mem_wdata_i (mem_wdata_i),
        .mem_wr_i    (mem_wr_i),
        .con_valid_o (con_valid_o),
        .con_data_o  (con_data_o),
        .con_ready_i (con_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [15:0] exp;
    } exp_t;

    exp_t       rd_q[$];
    logic [7:0] con_q[$];
    int         errors = 0;
    int         checks = 0;
    int         ncyc   = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: check console handshake, update model, advance, check read data.
    task automatic step(input bit con_push = 1'b0, input logic [7:0] con_byte = 8'h00);
        bit   issued;
        exp_t e;
        issued = mem_rd_i;
        if (con_ready_i) begin
            if (con_q.size() != 0) begin
                chk("con_valid", 16'(con_valid_o), 16'h0001);
                chk("con_data", 16'(con_data_o), 16'(con_q.pop_front()));
            end else begin
                chk("con_idle", 16'(con_valid_o), 16'h0000);
            end
        end
        if (con_push && con_q.size() < 16) con_q.push_back(con_byte);
        @(negedge clk);
        ncyc++;
        if (issued && rd_q.size() != 0) begin
            e = rd_q.pop_front();
            chk(e.tag, mem_rdata_o, e.exp);
        end
    endtask

    task automatic bus(input bit wr, input logic [15:0] wa, input logic [15:0] wd,
                       input bit rd, input logic [15:0] ra, input logic [15:0] exp,
                       input string tag);
        exp_t e;
        mem_wr_i    = wr;
        mem_waddr_i = wa;
        mem_wdata_i = wd;
        mem_rd_i    = rd;
        mem_raddr_i = ra;
        if (rd) begin
            e.tag = tag;
            e.exp = exp;
            rd_q.push_back(e);
        end
        step(wr && (wa == IO_BASE), wd[7:0]);
        mem_wr_i = 1'b0;
        mem_rd_i = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        bus(1'b1, a, d, 1'b0, 16'h0000, 16'h0000, "");
    endtask

    task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string tag);
        bus(1'b0, 16'h0000, 16'h0000, 1'b1, a, exp, tag);
    endtask

    initial begin
        logic [31:0] c;
        rst_n       = 1'b0;
        mem_raddr_i = '0;
        mem_rd_i    = 1'b0;
        mem_waddr_i = '0;
        mem_wdata_i = '0;
        mem_wr_i    = 1'b0;
        con_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rdata", mem_rdata_o, 16'h0000);
        chk("rst_con_valid", 16'(con_valid_o), 16'h0000);
        chk("rst_con_data", 16'(con_data_o), 16'h0000);
        rst_n = 1'b1;
        ncyc  = 0;

        rd(IO_BASE + 16'h1, 16'h0001, "status_after_reset");
        c = ncyc;
        rd(IO_BASE + 16'h2, c[15:0], "cycle_lo_early");

        // Counter boundary: low half at 0xFFFF, high half about to roll to 1.
        while (ncyc < 32'h0000_FFFF) step();
        rd(IO_BASE + 16'h2, 16'hFFFF, "cycle_lo_ffff");
        step();
        step();
        rd(IO_BASE + 16'h3, 16'h0000, "cycle_hi_shadow");
        c = ncyc;
        rd(IO_BASE + 16'h2, c[15:0], "cycle_lo_after_wrap");
        rd(IO_BASE + 16'h3, c[31:16], "cycle_hi_live");

        wr(16'h0010, 16'hBEEF);
        rd(16'h0010, 16'hBEEF, "ram_wr_then_rd");
        wr(16'h0020, 16'h1111);
        bus(1'b1, 16'h0020, 16'h2222, 1'b1, 16'h0020, SAME_CYC_EXP, "ram_same_cycle");
        rd(16'h0020, 16'h2222, "ram_after_same_cycle");
        step();
        chk("rdata_hold", mem_rdata_o, 16'h2222);

        wr(16'h8000, 16'h1234);
        rd(16'h8000, 16'h0000, "unmapped_rd");
        rd(IO_BASE + 16'h8, 16'h0000, "reserved_rd");
        rd(IO_BASE + 16'h0, 16'h0000, "con_data_rd");

        for (int i = 0; i < 16; i++) wr(IO_BASE, 16'(8'h41 + i));
        rd(IO_BASE + 16'h1, 16'h0002, "status_full");
        chk("head_before_drop", 16'(con_data_o), 16'h0041);
        wr(IO_BASE, 16'h0051);
        rd(IO_BASE + 16'h1, 16'h0006, "status_overflow");
        chk("head_after_drop", 16'(con_data_o), 16'h0041);
        bus(1'b1, IO_BASE + 16'h1, 16'h0004, 1'b1, IO_BASE + 16'h1, 16'h0006, "status_wr_rd_same");
        rd(IO_BASE + 16'h1, 16'h0002, "status_ovf_cleared");

        rd(16'h0010, 16'hBEEF, "ram_before_drain");
        con_ready_i = 1'b1;
        wr(IO_BASE, 16'h0052);
        for (int i = 0; i < 40 && con_q.size() != 0; i++) step();
        chk("drain_timeout", 16'(con_q.size()), 16'h0000);
        chk("valid_after_drain", 16'(con_valid_o), 16'h0000);
        rd(IO_BASE + 16'h1, 16'h0001, "status_empty");
        rd(16'h8000, 16'h0000, "unmapped_rd2");

        con_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) wr(IO_BASE, 16'(8'h61 + i));
        rd(16'h0010, 16'hBEEF, "ram_before_reset");
        con_ready_i = 1'b1;
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_con_valid", 16'(con_valid_o), 16'h0000);
        chk("midrst_rdata", mem_rdata_o, 16'h0000);
        chk("midrst_con_data", 16'(con_data_o), 16'h0000);
        con_q.delete();
        rd_q.delete();
        con_ready_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ncyc  = 0;
        rd(IO_BASE + 16'h1, 16'h0001, "status_after_midrst");
        c = ncyc;
        rd(IO_BASE + 16'h2, c[15:0], "cycle_restart");
        rd(IO_BASE + 16'h3, 16'h0000, "cycle_hi_restart");
        rd(16'h0010, 16'hBEEF, "ram_survives_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
